// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel 2-FF synchroniser, stability-qualified
// debounced level, registered press/release pulses and sticky press flags.
module button_debouncer #(
  parameter int NUM_BUTTONS   = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] press_flag,
  input  logic [NUM_BUTTONS-1:0] flag_clr
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [NUM_BUTTONS-1:0] flag_q, flag_d;
  logic [CW-1:0]          cnt_q [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d [NUM_BUTTONS];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TERM) begin
        // Input has disagreed with the level for STABLE_CYCLES samples: accept it.
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        if (sync2_q[i] != IDLE[i]) press_d[i] = 1'b1;
        else                       release_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // A new press outranks a clear arriving in the same cycle.
    flag_d = (flag_q & ~flag_clr) | press_d;
  end

  always_ff @(posedge clk_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset_reset) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      level_q   <= IDLE;
      press_q   <= '0;
      release_q <= '0;
      flag_q    <= '0;
      // NOTE: the counter array is reset too, so a button held through reset requalifies from zero.
      cnt_q     <= '{default: '0};
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_flag    = flag_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a window-based reference model pushes the
// expected outputs for every clock edge; a negedge monitor pops and compares them.
module tb_button_debouncer;

  localparam int N = 4;
  localparam int S = 4;
  localparam logic [N-1:0] IDLE = '1;

  logic         clk = 1'b0;
  logic         reset_reset;
  logic [N-1:0] btn_raw, flag_clr;
  logic [N-1:0] btn_level, press_pulse, release_pulse, press_flag;

  always #5 clk = ~clk;

  button_debouncer #(
    .NUM_BUTTONS  (N),
    .STABLE_CYCLES(S),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_flag   (press_flag),
    .flag_clr     (flag_clr)
  );

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] flag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: history of everything applied at each edge, and a rule that the
  // level flips once the synchronised input has disagreed with it over a full window.
  logic [N-1:0] raw_h[$];
  bit           rst_h[$];
  logic [N-1:0] m_level = '1;
  logic [N-1:0] m_flag  = '0;
  int           last_evt[N];

  // Value the debouncer sees at edge m: raw from two edges earlier, or IDLE if a reset
  // cleared the synchroniser in between.
  function automatic logic sync_val(int m, int i);
    if (m < 2 || rst_h[m-1] || rst_h[m-2]) return IDLE[i];
    return raw_h[m-2][i];
  endfunction

  task automatic model_edge(input logic [N-1:0] raw, input logic [N-1:0] clr, input bit rst);
    exp_t e;
    int   n;
    bit   fire;
    raw_h.push_back(raw);
    rst_h.push_back(rst);
    n = raw_h.size() - 1;
    e.press = '0;
    e.rel   = '0;
    if (rst) begin
      m_level = IDLE;
      m_flag  = '0;
      for (int i = 0; i < N; i++) last_evt[i] = n;
    end else begin
      for (int i = 0; i < N; i++) begin
        fire = (last_evt[i] <= n - S);
        for (int m = n - S + 1; m <= n; m++)
          if (fire && sync_val(m, i) == m_level[i]) fire = 1'b0;
        if (fire) begin
          m_level[i]  = ~m_level[i];
          last_evt[i] = n;
          if (m_level[i] == 1'b0) e.press[i] = 1'b1;
          else                    e.rel[i]   = 1'b1;
        end
        if (e.press[i])   m_flag[i] = 1'b1;
        else if (clr[i])  m_flag[i] = 1'b0;
      end
    end
    e.level = m_level;
    e.flag  = m_flag;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] raw, input logic [N-1:0] clr, input bit rst);
    btn_raw     = raw;
    flag_clr    = clr;
    reset_reset = rst;
    @(posedge clk);
    model_edge(raw, clr, rst);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("btn_level",     btn_level,     e.level);
        check("press_pulse",   press_pulse,   e.press);
        check("release_pulse", release_pulse, e.rel);
        check("press_flag",    press_flag,    e.flag);
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] r, c;
    logic         seen;
    int           hold[N];

    for (int i = 0; i < N; i++) last_evt[i] = 0;

    // Reset, then idle for 20 cycles.
    step(4'hF, 4'h0, 1'b1);
    step(4'hF, 4'h0, 1'b1);
    check("reset_level", btn_level, 4'hF);
    check("reset_flag",  press_flag, 4'h0);
    for (int k = 0; k < 20; k++) step(4'hF, 4'h0, 1'b0);
    check("idle_level", btn_level, 4'hF);

    // Press button 0: level falls on the 6th edge counting the first sample edge.
    for (int k = 0; k < 5; k++) step(4'hE, 4'h0, 1'b0);
    check("press0_not_early", btn_level, 4'hF);
    step(4'hE, 4'h0, 1'b0);
    check("press0_level", btn_level, 4'hE);
    check("press0_pulse", press_pulse, 4'h1);
    step(4'hE, 4'h0, 1'b0);
    check("press0_pulse_one_cycle", press_pulse, 4'h0);
    check("press0_flag", press_flag, 4'h1);

    // Bounce button 1 faster than the stability window.
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      r = 4'hE;
      r[1] = ((k / 2) % 2) != 0;
      step(r, 4'h0, 1'b0);
      seen |= press_pulse[1] | release_pulse[1];
    end
    for (int k = 0; k < 8; k++) begin
      step(4'hE, 4'h0, 1'b0);
      seen |= press_pulse[1] | release_pulse[1];
    end
    check("bounce1_no_pulse", {31'd0, seen}, 32'd0);
    check("bounce1_level", btn_level[1], 1'b1);
    check("bounce1_flag",  press_flag[1], 1'b0);

    // Release button 0, then clear its flag.
    for (int k = 0; k < 6; k++) step(4'hF, 4'h0, 1'b0);
    check("release0_pulse", release_pulse, 4'h1);
    check("release0_flag_kept", press_flag, 4'h1);
    step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'h1, 1'b0);
    check("clear0_flag", press_flag, 4'h0);

    // Press 2 and 3 together with a coinciding clear.
    for (int k = 0; k < 5; k++) step(4'h3, 4'h0, 1'b0);
    step(4'h3, 4'hC, 1'b0);
    check("press23_pulse", press_pulse, 4'hC);
    check("press23_flag_set_wins", press_flag, 4'hC);
    step(4'h3, 4'h0, 1'b0);
    check("press23_flag_held", press_flag, 4'hC);
    for (int k = 0; k < 8; k++) step(4'hF, 4'h0, 1'b0);

    // Reset while button 0 is mid-qualification (counter at 2).
    for (int k = 0; k < 4; k++) step(4'hE, 4'h0, 1'b0);
    step(4'hE, 4'h0, 1'b1);
    check("midreset_flag", press_flag, 4'h0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(4'hE, 4'h0, 1'b0);
      seen |= press_pulse[0];
    end
    check("midreset_no_early_pulse", {31'd0, seen}, 32'd0);
    check("midreset_level_held", btn_level, 4'hF);
    step(4'hE, 4'h0, 1'b0);
    check("midreset_level_fall", btn_level, 4'hE);
    check("midreset_pulse", press_pulse, 4'h1);

    // Randomised bouncing on all channels, with occasional clears and resets.
    r = 4'hE;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          r[i]    = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
        hold[i]--;
      end
      c = ($urandom_range(0, 7) == 0) ? N'($urandom) : 4'h0;
      step(r, c, ($urandom_range(0, 299) == 0));
    end
    for (int k = 0; k < 10; k++) step(4'hF, 4'h0, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
